multi_mode_counter: RTL and testbench
=====================================

MULTI_MODE_COUNTER -- requirements
Module: multi_mode_counter

Interface
REQ-001 Parameter P_CLK_HZ, default 50_000_000; input clock frequency in Hz.
REQ-002 Parameter P_FREQUENCY, default 1_000_000; o_clk frequency in Hz.
REQ-003 Parameter P_DIGITS, default 4; number of 4-bit digits, range 1..8.
REQ-004 Parameter P_INITIAL, default 16'h0B78, width 4*P_DIGITS; value loaded by set.
REQ-005 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 set  in  1  synchronous load of P_INITIAL.
REQ-008 input_pause  in  1  freeze value.
REQ-009 dcrm  in  1  count direction: 1 = down, 0 = up.
REQ-010 shift_left2  in  1  shift-left request.
REQ-011 shift_right1  in  1  shift-right request.
REQ-012 nsyst  in  1  number system: 1 = hex, 0 = decimal (BCD).
REQ-013 o_clk  out  1  divided clock, 50% duty.
REQ-014 o_value  out  4*P_DIGITS  current register value.
REQ-015 o_seg  out  [P_DIGITS-1:0][6:0]  active-low segments {g,f,e,d,c,b,a}; index 0 is the least-significant digit.
REQ-016 o_tc  out  1  one-i_clk-cycle terminal-count pulse.
REQ-017 LEDS  out  10  status: [0] o_clk, [1] input_pause, [2] dcrm, [3] nsyst, [4] sticky wrap flag, [9:5] 0.

Function
REQ-018 o_clk SHALL toggle every H = P_CLK_HZ/(2*P_FREQUENCY) i_clk cycles; the tick is the i_clk cycle in which o_clk rises.
REQ-019 Priority per i_clk edge SHALL be: nsyst change > set > input_pause > shift_left2 > shift_right1 > count.
REQ-020 A change of nsyst (registered copy versus input) SHALL clear o_value to 0 on that edge.
REQ-021 set SHALL load P_INITIAL on the next edge regardless of tick; in decimal mode any nibble >9 loads as 9.
REQ-022 Shift and count SHALL act only on tick edges and only when input_pause=0.
REQ-023 Hex mode: shift_left2 SHALL rotate left 2 bits; shift_right1 SHALL rotate right 1 bit.
REQ-024 Decimal mode: shift_left2 SHALL shift left 2 digits and shift_right1 SHALL shift right 1 digit, both zero-filled.
REQ-025 Hex count SHALL wrap modulo 2^(4*P_DIGITS); decimal count SHALL use per-digit BCD carry/borrow and wrap between 0 and all-9s.
REQ-026 o_tc SHALL pulse on the edge where a count wraps; the wrap SHALL also set LEDS[4], which is cleared only by reset or set.
REQ-027 o_seg SHALL be combinational from o_value: hex glyphs 0-F; in decimal mode nibbles >9 SHALL blank (7'h7F).

Reset
REQ-028 While reset=0, the block SHALL hold o_value=0, o_clk=0, o_tc=0, LEDS[4]=0 and the divider count at 0, with the nsyst copy loaded from the input; o_seg SHALL show 0 on every digit.
REQ-029 Reset mid-operation SHALL abort any pending tick action; the first tick after release occurs H cycles later.

Configuration
REQ-030 Macro COUNTER_SATURATE_EN defined: count SHALL saturate at 0 (down) or at the maximum (up), o_tc SHALL pulse on the edge where the count reaches the limit, and LEDS[4] SHALL stay 0; undefined: the wrap behaviour of REQ-025/REQ-026 applies.

Structure
REQ-031 Package counter_pkg SHALL hold the number-system enum, the seven-segment glyph table constant and the BCD increment/decrement functions.
REQ-032 Sub-module seg7_decoder (one 4-bit digit to 7 segments, with a blank input) SHALL be instantiated P_DIGITS times in a generate loop.

Verification
REQ-033 Defaults: release reset, pulse set -> o_value=16'h0B78; then 4 ticks, up, hex -> 16'h0B7C, with ticks 50 i_clk cycles apart.
REQ-034 Hex, value 0, dcrm=1, one tick -> 16'hFFFF with a single-cycle o_tc and LEDS[4]=1; with COUNTER_SATURATE_EN -> stays 16'h0000 with an o_tc pulse.
REQ-035 nsyst 1->0 -> o_value=0 next edge; down tick -> 16'h9999, o_tc pulse; up tick -> 16'h0000.
REQ-036 Hex 16'h0B78: shift_left2 tick -> 16'h2DE0; from 16'h0B78 shift_right1 tick -> 16'h05BC; decimal 16'h1234: shift_left2 -> 16'h3400, shift_right1 -> 16'h0123.
REQ-037 input_pause=1 for 10 ticks -> o_value unchanged while o_clk keeps toggling; set during pause -> P_INITIAL loaded.
REQ-038 reset low mid-count, off the clock edge -> all outputs reach reset values without waiting for an i_clk edge.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types, glyph table and BCD step helpers for multi_mode_counter.
// Functions work on up to 8 digits; callers pass the live digit count.
package counter_pkg;

    typedef enum logic {
        NS_DEC = 1'b0,
        NS_HEX = 1'b1
    } nsyst_e;

    localparam int MAX_DIGITS = 8;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}, indexed by nibble value.
    localparam logic [6:0] SEG_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [31:0] bcd_inc(
        input logic [31:0] v,
        input int          digits
    );
        logic [31:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits && c) begin
                if (r[i*4 +: 4] >= 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] bcd_dec(
        input logic [31:0] v,
        input int          digits
    );
        logic [31:0] r;
        logic        b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits && b) begin
                if (r[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = 4'd9;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Force every nibble into 0..9 so a decimal load stays valid BCD.
    function automatic logic [31:0] bcd_clamp(
        input logic [31:0] v,
        input int          digits
    );
        logic [31:0] r;
        r = v;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits && r[i*4 +: 4] > 4'd9) begin
                r[i*4 +: 4] = 4'd9;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// One nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
// Ports: digit (4b), blank (forces all segments off), seg (7b).
module seg7_decoder
    import counter_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_GLYPH[digit];
        if (blank) begin
            seg = SEG_BLANK;
        end
    end

endmodule

// File: rtl/multi_mode_counter.sv
// Hex/BCD up/down counter with shifts, clock divider and 7-seg outputs.
// Ports: i_clk, reset (async low), set, input_pause, dcrm, shift_left2,
//   shift_right1, nsyst in; o_clk, o_value, o_seg, o_tc, LEDS out.
// Option: define COUNTER_SATURATE_EN to saturate instead of wrapping.
module multi_mode_counter
    import counter_pkg::*;
#(
    parameter int P_CLK_HZ    = 50_000_000,
    parameter int P_FREQUENCY = 1_000_000,
    parameter int P_DIGITS    = 4,
    parameter logic [4*P_DIGITS-1:0] P_INITIAL =
        (4*P_DIGITS)'('h0B78)
) (
    input  logic                     i_clk,
    input  logic                     reset,
    input  logic                     set,
    input  logic                     input_pause,
    input  logic                     dcrm,
    input  logic                     shift_left2,
    input  logic                     shift_right1,
    input  logic                     nsyst,
    output logic                     o_clk,
    output logic [4*P_DIGITS-1:0]    o_value,
    output logic [P_DIGITS-1:0][6:0] o_seg,
    output logic                     o_tc,
    output logic [9:0]               LEDS
);

    localparam int W  = 4 * P_DIGITS;
    localparam int H  = P_CLK_HZ / (2 * P_FREQUENCY);
    localparam int HC = (H < 1) ? 1 : H;
    localparam int CW = (HC > 1) ? $clog2(HC) : 1;

    localparam logic [W-1:0] ALL9 = {P_DIGITS{4'h9}};
    localparam logic [W-1:0] ALLF = {W{1'b1}};

    logic [CW-1:0] div_cnt;
    logic          clk_q;
    logic          tick;

    logic [W-1:0]  value_q, value_d;
    logic          tc_q, tc_d;
    logic          wrap_q, wrap_d;
    nsyst_e        ns_q;
    logic          hex;

    logic [31:0]   inc_w, dec_w, clamp_w;
    logic [W-1:0]  step_v, limit_v, max_v;
    logic          at_limit;

    // Divider: o_clk toggles every HC cycles, tick on its rising edge.
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            clk_q   <= 1'b0;
        end else if (div_cnt == CW'(HC - 1)) begin
            div_cnt <= '0;
            clk_q   <= ~clk_q;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

    assign tick = (div_cnt == CW'(HC - 1)) && !clk_q;
    assign hex  = (ns_q == NS_HEX);

    always_comb begin
        inc_w   = bcd_inc(32'(value_q), P_DIGITS);
        dec_w   = bcd_dec(32'(value_q), P_DIGITS);
        clamp_w = bcd_clamp(32'(P_INITIAL), P_DIGITS);
        max_v   = hex ? ALLF : ALL9;
        limit_v = dcrm ? '0 : max_v;
        at_limit = (value_q == limit_v);
        if (hex) begin
            step_v = dcrm ? value_q - W'(1) : value_q + W'(1);
        end else begin
            step_v = dcrm ? dec_w[W-1:0] : inc_w[W-1:0];
        end
    end

    always_comb begin
        value_d = value_q;
        tc_d    = 1'b0;
        wrap_d  = wrap_q;
        if (nsyst != ns_q) begin
            value_d = '0;
        end else if (set) begin
            value_d = hex ? P_INITIAL : clamp_w[W-1:0];
            wrap_d  = 1'b0;
        end else if (input_pause) begin
            value_d = value_q;
        end else if (tick) begin
            if (shift_left2) begin
                if (hex) begin
                    value_d = {value_q[W-3:0], value_q[W-1:W-2]};
                end else begin
                    value_d = value_q << 8;
                end
            end else if (shift_right1) begin
                if (hex) begin
                    value_d = {value_q[0], value_q[W-1:1]};
                end else begin
                    value_d = value_q >> 4;
                end
            end else begin
`ifdef COUNTER_SATURATE_EN
                value_d = at_limit ? value_q : step_v;
                tc_d    = at_limit || (step_v == limit_v);
`else
                value_d = step_v;
                tc_d    = at_limit;
                wrap_d  = wrap_q | at_limit;
`endif
            end
        end
    end

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            value_q <= '0;
            tc_q    <= 1'b0;
            wrap_q  <= 1'b0;
            ns_q    <= nsyst_e'(nsyst);
        end else begin
            value_q <= value_d;
            tc_q    <= tc_d;
            wrap_q  <= wrap_d;
            ns_q    <= nsyst_e'(nsyst);
        end
    end

    for (genvar g = 0; g < P_DIGITS; g++) begin : g_seg
        seg7_decoder u_dec (
            .digit (value_q[g*4 +: 4]),
            .blank (!hex && (value_q[g*4 +: 4] > 4'd9)),
            .seg   (o_seg[g])
        );
    end

    assign o_clk   = clk_q;
    assign o_value = value_q;
    assign o_tc    = tc_q;
    assign LEDS    = {5'b0, wrap_q, nsyst, dcrm, input_pause, clk_q};

endmodule

// File: tb/tb_multi_mode_counter.sv
// Directed bench for multi_mode_counter (default parameters).
// Honours COUNTER_SATURATE_EN when the build defines it.
module tb_multi_mode_counter;

    logic            i_clk = 1'b0;
    logic            reset;
    logic            set;
    logic            input_pause;
    logic            dcrm;
    logic            shift_left2;
    logic            shift_right1;
    logic            nsyst;
    logic            o_clk;
    logic [15:0]     o_value;
    logic [3:0][6:0] o_seg;
    logic            o_tc;
    logic [9:0]      LEDS;

    int errors = 0;
    int checks = 0;

    always #5 i_clk = ~i_clk;

    multi_mode_counter dut (
        .i_clk        (i_clk),
        .reset        (reset),
        .set          (set),
        .input_pause  (input_pause),
        .dcrm         (dcrm),
        .shift_left2  (shift_left2),
        .shift_right1 (shift_right1),
        .nsyst        (nsyst),
        .o_clk        (o_clk),
        .o_value      (o_value),
        .o_seg        (o_seg),
        .o_tc         (o_tc),
        .LEDS         (LEDS)
    );

    task automatic wait_tick(output int n);
        n = 0;
        while (o_clk === 1'b1 && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        while (o_clk !== 1'b1 && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout: waited %0d cycles, limit 200", n);
        end
    endtask

    task automatic do_tick();
        int n;
        input_pause = 1'b0;
        wait_tick(n);
        input_pause = 1'b1;
    endtask

    task automatic pulse_set();
        set = 1'b1;
        @(negedge i_clk);
        set = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set = 1'b0;
        input_pause = 1'b1;
        dcrm = 1'b0;
        shift_left2 = 1'b0;
        shift_right1 = 1'b0;
        nsyst = 1'b1;
        repeat (3) @(negedge i_clk);
        checks++;
        if (o_value !== 16'h0000) begin
            errors++;
            $display("FAIL rst_value: got %h want 0000", o_value);
        end
        checks++;
        if (o_clk !== 1'b0 || o_tc !== 1'b0) begin
            errors++;
            $display("FAIL rst_clk_tc: got %b%b want 00", o_clk, o_tc);
        end
        checks++;
        if (LEDS !== 10'b00_0000_1010) begin
            errors++;
            $display("FAIL rst_leds: got %b want 0000001010", LEDS);
        end
        checks++;
        if (o_seg !== {7'h40, 7'h40, 7'h40, 7'h40}) begin
            errors++;
            $display("FAIL rst_seg: got %h", o_seg);
        end
    endtask

    task automatic test_set_and_count();
        int n;
        reset = 1'b1;
        pulse_set();
        checks++;
        if (o_value !== 16'h0B78) begin
            errors++;
            $display("FAIL set_load: got %h want 0b78", o_value);
        end
        checks++;
        if (o_seg !== {7'h40, 7'h03, 7'h78, 7'h00}) begin
            errors++;
            $display("FAIL seg_hex: got %h", o_seg);
        end
        input_pause = 1'b0;
        wait_tick(n);
        checks++;
        if (o_value !== 16'h0B79) begin
            errors++;
            $display("FAIL count_1: got %h want 0b79", o_value);
        end
        for (int i = 2; i <= 4; i++) begin
            wait_tick(n);
            checks++;
            if (n !== 50) begin
                errors++;
                $display("FAIL tick_spacing: got %0d want 50", n);
            end
        end
        input_pause = 1'b1;
        checks++;
        if (o_value !== 16'h0B7C) begin
            errors++;
            $display("FAIL count_4: got %h want 0b7c", o_value);
        end
    endtask

    task automatic test_hex_wrap();
        nsyst = 1'b0;
        @(negedge i_clk);
        nsyst = 1'b1;
        @(negedge i_clk);
        checks++;
        if (o_value !== 16'h0000) begin
            errors++;
            $display("FAIL hex_clear: got %h want 0000", o_value);
        end
        dcrm = 1'b1;
        do_tick();
`ifdef COUNTER_SATURATE_EN
        checks++;
        if (o_value !== 16'h0000 || o_tc !== 1'b1 || LEDS[4] !== 1'b0) begin
            errors++;
            $display("FAIL hex_sat: got %h tc=%b f=%b want 0000 1 0",
                     o_value, o_tc, LEDS[4]);
        end
`else
        checks++;
        if (o_value !== 16'hFFFF || o_tc !== 1'b1 || LEDS[4] !== 1'b1) begin
            errors++;
            $display("FAIL hex_wrap: got %h tc=%b f=%b want ffff 1 1",
                     o_value, o_tc, LEDS[4]);
        end
`endif
        @(negedge i_clk);
        checks++;
        if (o_tc !== 1'b0) begin
            errors++;
            $display("FAIL tc_width: got %b want 0", o_tc);
        end
        dcrm = 1'b0;
        pulse_set();
        checks++;
        if (o_value !== 16'h0B78 || LEDS[4] !== 1'b0) begin
            errors++;
            $display("FAIL set_clr_flag: got %h f=%b want 0b78 0",
                     o_value, LEDS[4]);
        end
    endtask

    task automatic test_hex_shift();
        shift_left2 = 1'b1;
        do_tick();
        shift_left2 = 1'b0;
        checks++;
        if (o_value !== 16'h2DE0) begin
            errors++;
            $display("FAIL hex_shl2: got %h want 2de0", o_value);
        end
        pulse_set();
        shift_right1 = 1'b1;
        do_tick();
        checks++;
        if (o_value !== 16'h05BC) begin
            errors++;
            $display("FAIL hex_shr1: got %h want 05bc", o_value);
        end
        pulse_set();
        shift_left2 = 1'b1;
        do_tick();
        shift_left2 = 1'b0;
        shift_right1 = 1'b0;
        checks++;
        if (o_value !== 16'h2DE0) begin
            errors++;
            $display("FAIL shift_prio: got %h want 2de0", o_value);
        end
    endtask

    task automatic test_decimal();
        nsyst = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_value !== 16'h0000 || LEDS[3] !== 1'b0) begin
            errors++;
            $display("FAIL dec_clear: got %h ns=%b want 0000 0",
                     o_value, LEDS[3]);
        end
        dcrm = 1'b1;
        do_tick();
`ifdef COUNTER_SATURATE_EN
        checks++;
        if (o_value !== 16'h0000 || o_tc !== 1'b1) begin
            errors++;
            $display("FAIL dec_sat_dn: got %h tc=%b want 0000 1",
                     o_value, o_tc);
        end
`else
        checks++;
        if (o_value !== 16'h9999 || o_tc !== 1'b1) begin
            errors++;
            $display("FAIL dec_wrap_dn: got %h tc=%b want 9999 1",
                     o_value, o_tc);
        end
`endif
        @(negedge i_clk);
        dcrm = 1'b0;
        do_tick();
`ifdef COUNTER_SATURATE_EN
        checks++;
        if (o_value !== 16'h0001 || o_tc !== 1'b0) begin
            errors++;
            $display("FAIL dec_sat_up: got %h tc=%b want 0001 0",
                     o_value, o_tc);
        end
`else
        checks++;
        if (o_value !== 16'h0000 || o_tc !== 1'b1) begin
            errors++;
            $display("FAIL dec_wrap_up: got %h tc=%b want 0000 1",
                     o_value, o_tc);
        end
`endif
        pulse_set();
        checks++;
        if (o_value !== 16'h0978) begin
            errors++;
            $display("FAIL dec_clamp: got %h want 0978", o_value);
        end
        checks++;
        if (o_seg !== {7'h40, 7'h10, 7'h78, 7'h00}) begin
            errors++;
            $display("FAIL seg_dec: got %h", o_seg);
        end
        do_tick();
        do_tick();
        checks++;
        if (o_value !== 16'h0980) begin
            errors++;
            $display("FAIL bcd_carry: got %h want 0980", o_value);
        end
        dcrm = 1'b1;
        do_tick();
        dcrm = 1'b0;
        checks++;
        if (o_value !== 16'h0979) begin
            errors++;
            $display("FAIL bcd_borrow: got %h want 0979", o_value);
        end
        pulse_set();
        shift_left2 = 1'b1;
        do_tick();
        shift_left2 = 1'b0;
        checks++;
        if (o_value !== 16'h7800) begin
            errors++;
            $display("FAIL dec_shl2: got %h want 7800", o_value);
        end
        pulse_set();
        shift_right1 = 1'b1;
        do_tick();
        shift_right1 = 1'b0;
        checks++;
        if (o_value !== 16'h0097) begin
            errors++;
            $display("FAIL dec_shr1: got %h want 0097", o_value);
        end
    endtask

    task automatic test_pause();
        int n;
        pulse_set();
        do_tick();
        for (int i = 0; i < 10; i++) begin
            wait_tick(n);
            checks++;
            if (o_value !== 16'h0979 || o_clk !== 1'b1) begin
                errors++;
                $display("FAIL pause_hold: got %h clk=%b want 0979 1",
                         o_value, o_clk);
            end
        end
        pulse_set();
        checks++;
        if (o_value !== 16'h0978) begin
            errors++;
            $display("FAIL pause_set: got %h want 0978", o_value);
        end
    endtask

    task automatic test_async_reset();
        int n;
        input_pause = 1'b0;
        wait_tick(n);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (o_value !== 16'h0000 || o_clk !== 1'b0 ||
            o_tc !== 1'b0 || LEDS[4] !== 1'b0) begin
            errors++;
            $display("FAIL async_rst: got %h clk=%b tc=%b f=%b",
                     o_value, o_clk, o_tc, LEDS[4]);
        end
        @(negedge i_clk);
        reset = 1'b1;
        wait_tick(n);
        input_pause = 1'b1;
        checks++;
        if (n !== 25 || o_value !== 16'h0001) begin
            errors++;
            $display("FAIL first_tick: got n=%0d %h want 25 0001",
                     n, o_value);
        end
    endtask

    initial begin
        test_reset();
        test_set_and_count();
        test_hex_wrap();
        test_hex_shift();
        test_decimal();
        test_pause();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
